cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
Shares the single external memory command/response port between the instruction-cache miss path and the data-cache miss/write path. Arbitrates round-robin, sequences each transaction through command issue and response capture, and returns read data plus a one-cycle done pulse to the winning requester. Drives the pipeline `Stall` that the datapath uses to freeze its pipeline registers and PC. A timeout watchdog guarantees forward progress.

Parameters:
ADDR_W, 32, width of requester and memory addresses
TIMEOUT_CYCLES, 1024, cycles spent in CMD+RESP before forced completion; must be ≥2
ERR_DATA, 32'hDEADBEEF, read data returned on timeout

Ports:
CLK  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
ic_req  in  1  icache read request, level, held until ic_done
ic_addr  in  ADDR_W  icache read address
ic_rdata  out  32  read data for icache, valid while ic_done=1
ic_done  out  1  one-cycle completion pulse to icache
dc_req  in  1  dcache request, level, held until dc_done
dc_we  in  1  1=write, 0=read
dc_addr  in  ADDR_W  dcache address
dc_wdata  in  32  write data
dc_wmask  in  4  byte write enables, bit3=bits[31:24]
dc_rdata  out  32  read data for dcache, valid while dc_done=1
dc_done  out  1  one-cycle completion pulse to dcache
mem_cmd_valid  out  1  command valid
mem_cmd_ready  in  1  memory accepts command
mem_cmd_rnw  out  1  1=read, 0=write
mem_cmd_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
mem_wdata  out  32  write data
mem_wmask  out  4  write byte mask (4'b0000 on reads)
mem_rdata_valid  in  1  read response valid
mem_rdata  in  32  read response data
Stall  out  1  pipeline stall
err  out  1  sticky timeout flag

Behaviour:
- Reset (reset=0, async): state=IDLE, last_grant=IC, timeout counter=0, err=0. All outputs except Stall are 0; Stall follows its combinational equation. A reset mid-transaction abandons it and produces no done pulse; the memory side must also be reset.
- Requesters hold their req and fields stable until they see done, then drop req in the next cycle. Icache requests are always reads.
- Stall = (ic_req & ~ic_done) | (dc_req & ~dc_done). This is combinational.
- FSM states: IDLE, CMD, RESP, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Single req: grant it.
  - Both req: grant the requester not equal to last_grant. After reset the dcache wins the first tie.
  - On grant: latch grant, rnw, word-aligned addr, wdata, and wmask; update last_grant; clear counter; go to CMD.
- CMD:
  - mem_cmd_valid=1 with the latched fields, held stable until ready.
  - On mem_cmd_ready=1: a write goes to DONE; a read goes to RESP.
- RESP:
  - mem_rdata_valid is sampled only in this state. The memory never returns data in the same cycle as command acceptance.
  - On mem_rdata_valid=1: capture mem_rdata into the granted requester's rdata register, then go to DONE.
- DONE:
  - Assert the granted requester's done for exactly one cycle. rdata holds the captured value; ic_rdata and dc_rdata hold their value until the next capture.
  - Next state is IDLE. The just-served requester is excluded from arbitration in that IDLE cycle.
- Timeout:
  - Counter increments each cycle in CMD or RESP.
  - When it reaches TIMEOUT_CYCLES-1: go to DONE, deassert mem_cmd_valid, set rdata=ERR_DATA for a read, set err=1.
  - err clears only on reset.
- Minimum latency with zero-wait memory, from req rising in cycle T:
  - Write: CMD at T+1, done at T+2.
  - Read: RESP at T+2, rdata_valid at T+2, done at T+3.
- At most one transaction is outstanding at any time.

Test Plan:
- dc write: addr=0x10000006, wdata=0x11223344, wmask=4'b0011, ready=1 → one mem command with addr 0x10000004, rnw=0, mask 0011; dc_done at T+2; Stall high T..T+1, low at T+2.
- ic read: addr=0x40000100, memory returns 0xCAFEF00D one cycle after accept → ic_rdata=0xCAFEF00D with ic_done at T+3; dc_done stays 0.
- Both req in the same cycle after reset → dcache served first, icache second. Repeat the simultaneous pair → dcache first again. Verify with three back-to-back contested pairs that grants alternate with no starvation.
- mem_cmd_ready held 0 for 5 cycles → mem_cmd_valid, address, and data remain stable for all 5 cycles; exactly one command is issued.
- TIMEOUT_CYCLES=8, read with no response → done after 8 cycles in CMD+RESP; rdata=0xDEADBEEF; err=1 and stays 1 through later good transactions.
- Drive reset=0 while in RESP → all outputs except Stall drop to 0 immediately (async) with no done pulse. After release with dc_req=1, a clean transaction completes.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one memory command/response port between
// the icache miss path and the dcache miss/write path, with a timeout watchdog.
module cache_mem_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [31:0]       ic_rdata,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [31:0]       dc_wdata,
    input  logic [3:0]        dc_wmask,
    output logic [31:0]       dc_rdata,
    output logic              dc_done,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_cmd_rnw,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_rdata_valid,
    input  logic [31:0]       mem_rdata,
    output logic              Stall,
    output logic              err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_RESP,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic              gnt_dc_q, gnt_dc_d;
    logic              last_dc_q, last_dc_d;
    logic              excl_q, excl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rnw_q, rnw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wmask_q, wmask_d;
    logic [31:0]       ic_rdata_q, ic_rdata_d;
    logic [31:0]       dc_rdata_q, dc_rdata_d;
    logic              err_q, err_d;

    logic              ic_elig, dc_elig, pick_dc, tmo;
    logic              cap_en;
    logic [31:0]       cap_val;
    logic              unused_addr_lsbs;

    assign unused_addr_lsbs = ^{ic_addr[1:0], dc_addr[1:0]};

    // The requester served last is masked for the one IDLE cycle after DONE.
    assign ic_elig = ic_req & ~(excl_q & ~last_dc_q);
    assign dc_elig = dc_req & ~(excl_q & last_dc_q);
    assign pick_dc = dc_elig & (~ic_elig | ~last_dc_q);
    assign tmo     = (cnt_q == CNT_MAX);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            gnt_dc_q   <= 1'b0;
            last_dc_q  <= 1'b0;
            excl_q     <= 1'b0;
            cnt_q      <= '0;
            rnw_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            ic_rdata_q <= '0;
            dc_rdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_dc_q   <= gnt_dc_d;
            last_dc_q  <= last_dc_d;
            excl_q     <= excl_d;
            cnt_q      <= cnt_d;
            rnw_q      <= rnw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            ic_rdata_q <= ic_rdata_d;
            dc_rdata_q <= dc_rdata_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_dc_d  = gnt_dc_q;
        last_dc_d = last_dc_q;
        excl_d    = 1'b0;
        cnt_d     = cnt_q;
        rnw_d     = rnw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        err_d     = err_q;
        cap_en    = 1'b0;
        cap_val   = mem_rdata;
        unique case (state_q)
            S_IDLE: begin
                if (ic_elig || dc_elig) begin
                    state_d   = S_CMD;
                    gnt_dc_d  = pick_dc;
                    last_dc_d = pick_dc;
                    cnt_d     = '0;
                    if (pick_dc) begin
                        rnw_d   = ~dc_we;
                        addr_d  = {dc_addr[ADDR_W-1:2], 2'b00};
                        wdata_d = dc_wdata;
                        wmask_d = dc_we ? dc_wmask : 4'b0000;
                    end else begin
                        rnw_d   = 1'b1;
                        addr_d  = {ic_addr[ADDR_W-1:2], 2'b00};
                        wdata_d = '0;
                        wmask_d = 4'b0000;
                    end
                end
            end
            S_CMD: begin
                cnt_d = cnt_q + 1'b1;
                if (tmo) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    cap_en  = rnw_q;
                    cap_val = ERR_DATA;
                end else if (mem_cmd_ready) begin
                    state_d = rnw_q ? S_RESP : S_DONE;
                end
            end
            S_RESP: begin
                cnt_d = cnt_q + 1'b1;
                if (tmo) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    cap_en  = 1'b1;
                    cap_val = ERR_DATA;
                end else if (mem_rdata_valid) begin
                    state_d = S_DONE;
                    cap_en  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                excl_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ic_rdata_d = (cap_en && !gnt_dc_q) ? cap_val : ic_rdata_q;
    assign dc_rdata_d = (cap_en && gnt_dc_q) ? cap_val : dc_rdata_q;

    always_comb begin
        mem_cmd_valid = (state_q == S_CMD) && !tmo;
        ic_done       = (state_q == S_DONE) && !gnt_dc_q;
        dc_done       = (state_q == S_DONE) && gnt_dc_q;
        Stall         = (ic_req & ~ic_done) | (dc_req & ~dc_done);
    end

    assign mem_cmd_rnw  = rnw_q;
    assign mem_cmd_addr = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_wmask    = wmask_q;
    assign ic_rdata     = ic_rdata_q;
    assign dc_rdata     = dc_rdata_q;
    assign err          = err_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a one-cycle-latency memory
// responder and a short watchdog so the timeout path is reachable.
module tb_cache_mem_arbiter;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        ic_req = 1'b0;
    logic [31:0] ic_addr = '0;
    logic [31:0] ic_rdata;
    logic        ic_done;
    logic        dc_req = 1'b0;
    logic        dc_we = 1'b0;
    logic [31:0] dc_addr = '0;
    logic [31:0] dc_wdata = '0;
    logic [3:0]  dc_wmask = '0;
    logic [31:0] dc_rdata;
    logic        dc_done;
    logic        mem_cmd_valid;
    logic        mem_cmd_ready = 1'b1;
    logic        mem_cmd_rnw;
    logic [31:0] mem_cmd_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rdata_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        Stall;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    int          cmd_cnt = 0;
    bit          resp_en = 1'b1;
    logic [31:0] resp_data = '0;
    bit          acc_rd;

    cache_mem_arbiter #(
        .ADDR_W(32),
        .TIMEOUT_CYCLES(8),
        .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .ic_req(ic_req),
        .ic_addr(ic_addr),
        .ic_rdata(ic_rdata),
        .ic_done(ic_done),
        .dc_req(dc_req),
        .dc_we(dc_we),
        .dc_addr(dc_addr),
        .dc_wdata(dc_wdata),
        .dc_wmask(dc_wmask),
        .dc_rdata(dc_rdata),
        .dc_done(dc_done),
        .mem_cmd_valid(mem_cmd_valid),
        .mem_cmd_ready(mem_cmd_ready),
        .mem_cmd_rnw(mem_cmd_rnw),
        .mem_cmd_addr(mem_cmd_addr),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .mem_rdata_valid(mem_rdata_valid),
        .mem_rdata(mem_rdata),
        .Stall(Stall),
        .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt;
        @(posedge CLK);
        #1;
    endtask

    // Latency in cycles from the request cycle to the done pulse, -1 if none.
    task automatic wait_done(input bit dc, output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (dc ? dc_done : ic_done) begin
                lat = i;
                break;
            end
            nxt();
        end
    endtask

    // Memory: reads accepted at an edge answer in the following cycle.
    initial begin
        forever begin
            @(negedge CLK);
            acc_rd = mem_cmd_valid && mem_cmd_ready && mem_cmd_rnw;
            if (mem_cmd_valid && mem_cmd_ready)
                cmd_cnt++;
            @(posedge CLK);
            #1;
            mem_rdata_valid = acc_rd && resp_en;
            mem_rdata = resp_data;
        end
    end

    task automatic run_pair(input string tag);
        bit dc_seen, ic_seen, dc_first;
        dc_seen = 1'b0;
        ic_seen = 1'b0;
        dc_first = 1'b0;
        nxt();
        ic_req = 1'b1;
        ic_addr = 32'h0000_2000;
        dc_req = 1'b1;
        dc_we = 1'b1;
        dc_addr = 32'h0000_3000;
        dc_wdata = 32'h0BAD_F00D;
        dc_wmask = 4'hF;
        for (int i = 0; i < 30 && !(dc_seen && ic_seen); i++) begin
            @(negedge CLK);
            if (dc_done && !dc_seen) begin
                dc_seen = 1'b1;
                dc_first = !ic_seen;
            end
            if (ic_done && !ic_seen)
                ic_seen = 1'b1;
            nxt();
            if (dc_seen) dc_req = 1'b0;
            if (ic_seen) ic_req = 1'b0;
        end
        chk({tag, "_both"}, {dc_seen, ic_seen}, 2'b11);
        chk({tag, "_dc_first"}, dc_first, 1'b1);
    endtask

    initial begin
        int lat;
        int c0;
        resp_data = 32'h1111_2222;

        @(negedge CLK);
        chk("rst_ic_done", ic_done, 1'b0);
        chk("rst_dc_done", dc_done, 1'b0);
        chk("rst_valid", mem_cmd_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_addr", mem_cmd_addr, 32'h0);
        chk("rst_stall", Stall, 1'b0);
        nxt();
        reset = 1'b1;

        run_pair("pair1");
        run_pair("pair2");
        run_pair("pair3");

        // dcache write, zero-wait memory
        nxt();
        c0 = cmd_cnt;
        dc_req = 1'b1;
        dc_we = 1'b1;
        dc_addr = 32'h1000_0006;
        dc_wdata = 32'h1122_3344;
        dc_wmask = 4'b0011;
        @(negedge CLK);
        chk("wr_stall_t0", Stall, 1'b1);
        nxt();
        @(negedge CLK);
        chk("wr_valid", mem_cmd_valid, 1'b1);
        chk("wr_addr", mem_cmd_addr, 32'h1000_0004);
        chk("wr_rnw", mem_cmd_rnw, 1'b0);
        chk("wr_mask", mem_wmask, 4'b0011);
        chk("wr_wdata", mem_wdata, 32'h1122_3344);
        chk("wr_stall_t1", Stall, 1'b1);
        nxt();
        @(negedge CLK);
        chk("wr_done_t2", dc_done, 1'b1);
        chk("wr_stall_t2", Stall, 1'b0);
        chk("wr_ic_done", ic_done, 1'b0);
        nxt();
        dc_req = 1'b0;
        chk("wr_cmds", cmd_cnt - c0, 1);

        // icache read, data one cycle after accept
        nxt();
        resp_data = 32'hCAFE_F00D;
        ic_req = 1'b1;
        ic_addr = 32'h4000_0100;
        nxt();
        @(negedge CLK);
        chk("rd_addr", mem_cmd_addr, 32'h4000_0100);
        chk("rd_rnw", mem_cmd_rnw, 1'b1);
        chk("rd_mask", mem_wmask, 4'b0000);
        nxt();
        @(negedge CLK);
        chk("rd_no_done_t2", ic_done, 1'b0);
        nxt();
        @(negedge CLK);
        chk("rd_done_t3", ic_done, 1'b1);
        chk("rd_rdata", ic_rdata, 32'hCAFE_F00D);
        chk("rd_dc_done", dc_done, 1'b0);
        nxt();
        ic_req = 1'b0;

        // memory stalls the command for 5 cycles
        nxt();
        c0 = cmd_cnt;
        mem_cmd_ready = 1'b0;
        dc_req = 1'b1;
        dc_we = 1'b1;
        dc_addr = 32'h2000_0008;
        dc_wdata = 32'hA5A5_5A5A;
        dc_wmask = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            nxt();
            @(negedge CLK);
            chk("hold_valid", mem_cmd_valid, 1'b1);
            chk("hold_addr", mem_cmd_addr, 32'h2000_0008);
            chk("hold_wdata", mem_wdata, 32'hA5A5_5A5A);
        end
        nxt();
        mem_cmd_ready = 1'b1;
        wait_done(1'b1, lat);
        chk("hold_lat", lat, 1);
        nxt();
        dc_req = 1'b0;
        chk("hold_cmds", cmd_cnt - c0, 1);

        // read with no response trips the watchdog
        nxt();
        resp_en = 1'b0;
        ic_req = 1'b1;
        ic_addr = 32'h5000_0040;
        wait_done(1'b0, lat);
        chk("tmo_lat", lat, 9);
        chk("tmo_rdata", ic_rdata, 32'hDEAD_BEEF);
        chk("tmo_err", err, 1'b1);
        nxt();
        ic_req = 1'b0;
        resp_en = 1'b1;

        nxt();
        dc_req = 1'b1;
        dc_we = 1'b1;
        dc_addr = 32'h0000_0100;
        wait_done(1'b1, lat);
        chk("post_tmo_lat", lat, 2);
        chk("post_tmo_err", err, 1'b1);
        nxt();
        dc_req = 1'b0;

        // async reset while waiting in RESP
        nxt();
        resp_en = 1'b0;
        dc_req = 1'b1;
        dc_we = 1'b0;
        dc_addr = 32'h0000_0200;
        nxt();
        nxt();
        @(negedge CLK);
        chk("ar_in_resp", mem_cmd_valid, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_err", err, 1'b0);
        chk("ar_ic_rdata", ic_rdata, 32'h0);
        chk("ar_addr", mem_cmd_addr, 32'h0);
        chk("ar_dc_done", dc_done, 1'b0);
        chk("ar_stall", Stall, 1'b1);
        nxt();
        @(negedge CLK);
        chk("ar_no_done", dc_done, 1'b0);
        nxt();
        resp_en = 1'b1;
        resp_data = 32'h1357_9BDF;
        reset = 1'b1;
        wait_done(1'b1, lat);
        chk("ar_after_lat", lat, 3);
        chk("ar_after_rdata", dc_rdata, 32'h1357_9BDF);
        chk("ar_after_err", err, 1'b0);
        nxt();
        dc_req = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
